// File: rtl/player_multishot_if.sv
// Player controller bundle: per-frame controls in, sprite/bullet/status state out.
// The player itself connects through the slave modport.
interface player_multishot_if #(
    parameter int bullets_p = 4
) ();
    logic                    frame_i;
    logic                    move_left_i;
    logic                    move_right_i;
    logic                    shoot_i;
    logic                    hit_i;
    logic                    add_life_i;
    logic [bullets_p-1:0]    hit_enemy_i;
    logic                    alive_o;
    logic [2:0]              state_o;
    logic [2:0]              lives_o;
    logic [9:0]              pos_left_o;
    logic [9:0]              pos_right_o;
    logic [bullets_p-1:0]    bullet_valid_o;
    logic [10*bullets_p-1:0] bullet_x_o;
    logic [10*bullets_p-1:0] bullet_y_o;
    logic                    shot_o;
    logic [11:0]             player_rgb_o;

    modport slave (
        input  frame_i, move_left_i, move_right_i, shoot_i, hit_i, add_life_i, hit_enemy_i,
        output alive_o, state_o, lives_o, pos_left_o, pos_right_o, bullet_valid_o,
               bullet_x_o, bullet_y_o, shot_o, player_rgb_o
    );

    modport master (
        output frame_i, move_left_i, move_right_i, shoot_i, hit_i, add_life_i, hit_enemy_i,
        input  alive_o, state_o, lives_o, pos_left_o, pos_right_o, bullet_valid_o,
               bullet_x_o, bullet_y_o, shot_o, player_rgb_o
    );
endinterface

// File: rtl/player_multishot.sv
// Space-invaders player: position, lives, ALIVE/HIT/DEAD life FSM and a multi-slot bullet pool.
// Define PLAYER_AUTOFIRE_EN to let a held fire button shoot repeatedly.
module player_multishot #(
    parameter int          screen_width_p  = 640,
    parameter int          player_width_p  = 32,
    parameter int          player_top_p    = 440,
    parameter int          step_p          = 4,
    parameter int          bullets_p       = 4,
    parameter int          bullet_w_p      = 2,
    parameter int          bullet_h_p      = 8,
    parameter int          bullet_speed_p  = 8,
    parameter int          cooldown_p      = 6,
    parameter int          start_lives_p   = 3,
    parameter int          max_lives_p     = 7,
    parameter int          invuln_frames_p = 60,
    parameter logic [11:0] color_p         = 12'hFFF
) (
    input logic               clk_i,
    input logic               reset_i,
    player_multishot_if.slave bus
);
    typedef enum logic [2:0] {
        ST_ALIVE = 3'b001,
        ST_HIT   = 3'b010,
        ST_DEAD  = 3'b100
    } state_e;

    localparam int CW = ($clog2(cooldown_p + 1) < 1) ? 1 : $clog2(cooldown_p + 1);
    localparam int IW = ($clog2(invuln_frames_p + 1) < 3) ? 3 : $clog2(invuln_frames_p + 1);

    localparam logic [9:0]    POS_CENTER  = 10'((screen_width_p - player_width_p) / 2);
    localparam logic [9:0]    POS_MAX     = 10'(screen_width_p - player_width_p);
    localparam logic [9:0]    STEP        = 10'(step_p);
    localparam logic [9:0]    RIGHT_OFS   = 10'(player_width_p - 1);
    localparam logic [9:0]    SPAWN_X_OFS = 10'(player_width_p / 2 - bullet_w_p / 2);
    localparam logic [9:0]    SPAWN_Y     = 10'(player_top_p - bullet_h_p);
    localparam logic [9:0]    SPEED       = 10'(bullet_speed_p);
    localparam logic [2:0]    LIVES_START = 3'(start_lives_p);
    localparam logic [2:0]    LIVES_MAX   = 3'(max_lives_p);
    localparam logic [CW-1:0] COOL_LOAD   = CW'(cooldown_p);
    localparam logic [IW-1:0] INV_LOAD    = IW'(invuln_frames_p);

    state_e               state_q, state_d;
    logic [2:0]           lives_q, lives_d;
    logic [9:0]           pos_q, pos_d;
    logic [9:0]           pos_right_q, pos_right_d;
    logic [CW-1:0]        cool_q, cool_d;
    logic [IW-1:0]        inv_q, inv_d;
    logic                 shoot_prev_q, shoot_prev_d;
    logic                 shot_q, shot_d;
    logic [11:0]          rgb_q, rgb_d;
    logic [bullets_p-1:0] valid_q, valid_d;
    logic [9:0]           bx_q [bullets_p];
    logic [9:0]           bx_d [bullets_p];
    logic [9:0]           by_q [bullets_p];
    logic [9:0]           by_d [bullets_p];

    logic                 can_act;
    logic                 shoot_ok;
    logic                 fire;
    logic                 found;
    logic [bullets_p-1:0] alloc_oh;
    logic [CW-1:0]        cool_next;

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        pos_d        = pos_q;
        cool_d       = cool_q;
        inv_d        = inv_q;
        shoot_prev_d = shoot_prev_q;
        valid_d      = valid_q;
        bx_d         = bx_q;
        by_d         = by_q;
        found        = 1'b0;
        alloc_oh     = '0;

        can_act = (state_q != ST_DEAD);

        if (bus.frame_i && can_act) begin
            if (bus.move_left_i && !bus.move_right_i)
                pos_d = (pos_q < STEP) ? 10'd0 : pos_q - STEP;
            else if (bus.move_right_i && !bus.move_left_i)
                pos_d = (pos_q > POS_MAX - STEP) ? POS_MAX : pos_q + STEP;
        end

        for (int k = 0; k < bullets_p; k++) begin
            if (!valid_q[k] && !found) begin
                alloc_oh[k] = 1'b1;
                found       = 1'b1;
            end
        end

`ifdef PLAYER_AUTOFIRE_EN
        shoot_ok = bus.shoot_i;
`else
        shoot_ok = bus.shoot_i && !shoot_prev_q;
`endif
        // The firing frame counts toward the gap, so shots land exactly cooldown_p frames apart.
        cool_next = (cool_q == '0) ? '0 : cool_q - 1'b1;
        fire      = bus.frame_i && can_act && shoot_ok && (cool_next == '0) && found;

        if (bus.frame_i) begin
            shoot_prev_d = bus.shoot_i;
            cool_d       = fire ? COOL_LOAD : cool_next;
        end
        shot_d = fire;

        for (int k = 0; k < bullets_p; k++) begin
            if (bus.frame_i && valid_q[k]) begin
                if (by_q[k] < SPEED) valid_d[k] = 1'b0;
                else                 by_d[k]    = by_q[k] - SPEED;
            end
            if (fire && alloc_oh[k]) begin
                valid_d[k] = 1'b1;
                bx_d[k]    = pos_q + SPAWN_X_OFS;
                by_d[k]    = SPAWN_Y;
            end
            if (bus.hit_enemy_i[k] && valid_q[k]) valid_d[k] = 1'b0;
        end

        case (state_q)
            ST_ALIVE: begin
                if (bus.hit_i) begin
                    if (bus.add_life_i) begin
                        state_d = ST_HIT;
                        inv_d   = INV_LOAD;
                    end else if (lives_q <= 3'd1) begin
                        state_d = ST_DEAD;
                        lives_d = 3'd0;
                        inv_d   = '0;
                    end else begin
                        state_d = ST_HIT;
                        lives_d = lives_q - 3'd1;
                        inv_d   = INV_LOAD;
                    end
                end else if (bus.add_life_i) begin
                    lives_d = (lives_q >= LIVES_MAX) ? LIVES_MAX : lives_q + 3'd1;
                end
            end
            ST_HIT: begin
                if (bus.add_life_i)
                    lives_d = (lives_q >= LIVES_MAX) ? LIVES_MAX : lives_q + 3'd1;
                if (bus.frame_i) begin
                    if (inv_q <= IW'(1)) begin
                        state_d = ST_ALIVE;
                        inv_d   = '0;
                    end else begin
                        inv_d = inv_q - 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                if (bus.add_life_i) begin
                    state_d = ST_ALIVE;
                    lives_d = 3'd1;
                    pos_d   = POS_CENTER;
                end
            end
            default: begin
                state_d = ST_ALIVE;
                inv_d   = '0;
            end
        endcase

        pos_right_d = pos_d + RIGHT_OFS;

        case (state_d)
            ST_ALIVE: rgb_d = color_p;
            ST_HIT:   rgb_d = inv_d[2] ? 12'h000 : color_p;
            default:  rgb_d = 12'h000;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= ST_ALIVE;
            lives_q      <= LIVES_START;
            pos_q        <= POS_CENTER;
            pos_right_q  <= POS_CENTER + RIGHT_OFS;
            cool_q       <= '0;
            inv_q        <= '0;
            shoot_prev_q <= 1'b0;
            shot_q       <= 1'b0;
            rgb_q        <= color_p;
            valid_q      <= '0;
            for (int k = 0; k < bullets_p; k++) begin
                bx_q[k] <= 10'd0;
                by_q[k] <= 10'd0;
            end
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            pos_q        <= pos_d;
            pos_right_q  <= pos_right_d;
            cool_q       <= cool_d;
            inv_q        <= inv_d;
            shoot_prev_q <= shoot_prev_d;
            shot_q       <= shot_d;
            rgb_q        <= rgb_d;
            valid_q      <= valid_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
        end
    end

    assign bus.alive_o        = (state_q != ST_DEAD);
    assign bus.state_o        = state_q;
    assign bus.lives_o        = lives_q;
    assign bus.pos_left_o     = pos_q;
    assign bus.pos_right_o    = pos_right_q;
    assign bus.bullet_valid_o = valid_q;
    assign bus.shot_o         = shot_q;
    assign bus.player_rgb_o   = rgb_q;

    for (genvar k = 0; k < bullets_p; k++) begin : g_flat
        assign bus.bullet_x_o[10*k +: 10] = bx_q[k];
        assign bus.bullet_y_o[10*k +: 10] = by_q[k];
    end
endmodule

// File: tb/tb_player_multishot.sv
// Directed bench for player_multishot: movement, bullet pool, cooldown and life FSM.
// Fire-button expectations follow the PLAYER_AUTOFIRE_EN setting of the build.
module tb_player_multishot;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    player_multishot_if #(.bullets_p(NB)) bus ();

    player_multishot #(.bullets_p(NB)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [9:0] slot_x(input int k);
        return bus.bullet_x_o[10*k +: 10];
    endfunction

    function automatic logic [9:0] slot_y(input int k);
        return bus.bullet_y_o[10*k +: 10];
    endfunction

    task automatic clear_inputs();
        bus.frame_i      = 1'b0;
        bus.move_left_i  = 1'b0;
        bus.move_right_i = 1'b0;
        bus.shoot_i      = 1'b0;
        bus.hit_i        = 1'b0;
        bus.add_life_i   = 1'b0;
        bus.hit_enemy_i  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk);
        bus.frame_i = 1'b1;
        @(negedge clk);
        bus.frame_i = 1'b0;
    endtask

    task automatic frame_kill(input logic [NB-1:0] mask);
        @(negedge clk);
        bus.frame_i     = 1'b1;
        bus.hit_enemy_i = mask;
        @(negedge clk);
        bus.frame_i     = 1'b0;
        bus.hit_enemy_i = '0;
    endtask

    task automatic pulse(input logic hit, input logic add, input logic [NB-1:0] kill);
        @(negedge clk);
        bus.hit_i       = hit;
        bus.add_life_i  = add;
        bus.hit_enemy_i = kill;
        @(negedge clk);
        bus.hit_i       = 1'b0;
        bus.add_life_i  = 1'b0;
        bus.hit_enemy_i = '0;
    endtask

    initial begin
        int exp_pos;
        int shots;
        int exp_shots;

        clear_inputs();
        // Reset values, sampled while reset is still asserted.
        repeat (4) @(negedge clk);
        chk("rst_pos_left", bus.pos_left_o, 304);
        chk("rst_pos_right", bus.pos_right_o, 335);
        chk("rst_lives", bus.lives_o, 3);
        chk("rst_state", bus.state_o, 3'b001);
        chk("rst_alive", bus.alive_o, 1);
        chk("rst_valid", bus.bullet_valid_o, 0);
        chk("rst_bx", bus.bullet_x_o, 0);
        chk("rst_by", bus.bullet_y_o, 0);
        chk("rst_shot", bus.shot_o, 0);
        chk("rst_rgb", bus.player_rgb_o, 12'hFFF);
        rst_n = 1'b1;
        @(negedge clk);

        // Walk left to the edge and hold there.
        bus.move_left_i = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            frame();
            exp_pos = (304 - 4 * i < 0) ? 0 : 304 - 4 * i;
            chk("left_pos", bus.pos_left_o, exp_pos);
        end
        chk("left_pos_right", bus.pos_right_o, 31);
        bus.move_left_i = 1'b0;

        // Walk right to the clamp, then both buttons hold.
        do_reset();
        bus.move_right_i = 1'b1;
        repeat (90) frame();
        chk("right_clamp", bus.pos_left_o, 608);
        chk("right_pos_right", bus.pos_right_o, 639);
        bus.move_left_i = 1'b1;
        repeat (5) frame();
        chk("both_hold", bus.pos_left_o, 608);
        clear_inputs();

        // Single shot and its full flight.
        do_reset();
        bus.shoot_i = 1'b1;
        frame();
        chk("shot_pulse", bus.shot_o, 1);
        chk("shot_valid", bus.bullet_valid_o, 4'b0001);
        chk("shot_x", slot_x(0), 319);
        chk("shot_y", slot_y(0), 432);
        bus.shoot_i = 1'b0;
        @(negedge clk);
        chk("shot_one_cycle", bus.shot_o, 0);
        repeat (54) frame();
        chk("flight_y0", slot_y(0), 0);
        chk("flight_valid_y0", bus.bullet_valid_o[0], 1);
        frame();
        chk("flight_exit", bus.bullet_valid_o[0], 0);

        // Fill the pool with spaced presses, hit the full pool, free a slot by kill.
        do_reset();
        for (int f = 0; f <= 25; f++) begin
            bus.shoot_i = ((f % 6) == 0);
            frame();
            chk($sformatf("pool_shot_f%0d", f), bus.shot_o, ((f % 6) == 0) && (f < 24));
        end
        bus.shoot_i = 1'b0;
        chk("pool_full", bus.bullet_valid_o, 4'b1111);
        chk("pool_y0", slot_y(0), 232);
        chk("pool_y3", slot_y(3), 376);
        pulse(1'b0, 1'b0, 4'b0010);
        chk("kill_slot1", bus.bullet_valid_o, 4'b1101);
        bus.shoot_i = 1'b1;
        frame();
        bus.shoot_i = 1'b0;
        chk("reuse_shot", bus.shot_o, 1);
        chk("reuse_valid", bus.bullet_valid_o, 4'b1111);
        chk("reuse_y1", slot_y(1), 432);
        chk("reuse_x1", slot_x(1), 319);
        chk("reuse_y0", slot_y(0), 224);
        frame_kill(4'b0001);
        chk("kill_over_flight", bus.bullet_valid_o, 4'b1110);
        chk("flight_y2", slot_y(2), 432 - 15 * 8);
        do_reset();
        chk("reset_drops", bus.bullet_valid_o, 0);
        chk("reset_by", bus.bullet_y_o, 0);

        // Held fire button.
        bus.shoot_i = 1'b1;
        shots = 0;
        repeat (40) begin
            frame();
            if (bus.shot_o) shots++;
        end
        bus.shoot_i = 1'b0;
`ifdef PLAYER_AUTOFIRE_EN
        exp_shots = 4;
`else
        exp_shots = 1;
`endif
        chk("held_shots", shots, exp_shots);
        chk("held_valid", bus.bullet_valid_o, (exp_shots == 4) ? 4'b1111 : 4'b0001);

        // Life FSM.
        do_reset();
        pulse(1'b1, 1'b0, '0);
        chk("hit_lives", bus.lives_o, 2);
        chk("hit_state", bus.state_o, 3'b010);
        chk("hit_rgb_blank", bus.player_rgb_o, 0);
        chk("hit_alive", bus.alive_o, 1);
        pulse(1'b1, 1'b0, '0);
        chk("hit_ignored", bus.lives_o, 2);
        pulse(1'b1, 1'b1, '0);
        chk("hit_add_in_hit", bus.lives_o, 3);
        chk("hit_add_state", bus.state_o, 3'b010);
        repeat (4) frame();
        chk("blink_on", bus.player_rgb_o, 12'hFFF);
        repeat (55) frame();
        chk("invuln_59", bus.state_o, 3'b010);
        frame();
        chk("invuln_done", bus.state_o, 3'b001);

        pulse(1'b1, 1'b0, '0);
        repeat (60) frame();
        pulse(1'b1, 1'b0, '0);
        repeat (60) frame();
        chk("two_hits_lives", bus.lives_o, 1);
        bus.move_right_i = 1'b1;
        repeat (5) frame();
        bus.move_right_i = 1'b0;
        chk("move_before_death", bus.pos_left_o, 324);
        pulse(1'b1, 1'b0, '0);
        chk("dead_lives", bus.lives_o, 0);
        chk("dead_state", bus.state_o, 3'b100);
        chk("dead_alive", bus.alive_o, 0);
        chk("dead_rgb", bus.player_rgb_o, 0);
        bus.move_left_i = 1'b1;
        bus.shoot_i     = 1'b1;
        repeat (3) frame();
        chk("dead_no_shot", bus.shot_o, 0);
        chk("dead_no_move", bus.pos_left_o, 324);
        chk("dead_no_bullet", bus.bullet_valid_o, 0);
        clear_inputs();
        pulse(1'b1, 1'b0, '0);
        chk("dead_hit_ignored", bus.state_o, 3'b100);
        pulse(1'b0, 1'b1, '0);
        chk("revive_lives", bus.lives_o, 1);
        chk("revive_state", bus.state_o, 3'b001);
        chk("revive_pos", bus.pos_left_o, 304);
        chk("revive_rgb", bus.player_rgb_o, 12'hFFF);
        pulse(1'b1, 1'b1, '0);
        chk("hitadd_alive_lives", bus.lives_o, 1);
        chk("hitadd_alive_state", bus.state_o, 3'b010);
        repeat (8) pulse(1'b0, 1'b1, '0);
        chk("lives_saturate", bus.lives_o, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
